// File: rtl/comarray_pkg.sv
// Shared definitions for the comarray sweep controller: FSM encoding,
// default geometry and the truth-table bit addressing helper.
package comarray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    localparam int WIDTH_DEF = 4;
    localparam int NOUT_DEF  = 3;
    localparam int DWELL_DEF = 2;

    // Output k of the array at input code `code` lives at bit k*2**width + code.
    function automatic int tt_index(input int k, input int code, input int width);
        return k * (2 ** width) + code;
    endfunction

endpackage

// File: rtl/comarray_tt_check.sv
// Captured truth table plus compare against the expected table latched at
// sweep start; tracks the number of mismatching codes and the lowest one.
module comarray_tt_check
    import comarray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NOUT  = NOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr,
    input  logic [NOUT*(2**WIDTH)-1:0]   exp_tt,
    input  logic [WIDTH-1:0]             code,
    input  logic [NOUT-1:0]              f_in,
    output logic [NOUT*(2**WIDTH)-1:0]   tt,
    output logic [WIDTH:0]               err_cnt,
    output logic [WIDTH-1:0]             first_err
);

    localparam int TT_W = NOUT * (2 ** WIDTH);
    localparam int IW   = $clog2(TT_W);

    logic [TT_W-1:0] exp_q;
    logic [NOUT-1:0] exp_bits;
    logic            mismatch;

    always_comb begin
        exp_bits = '0;
        for (int k = 0; k < NOUT; k++) begin
            exp_bits[k] = exp_q[IW'(tt_index(k, int'(code), WIDTH))];
        end
        mismatch = |(exp_bits ^ f_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= '0;
            tt        <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else if (clr) begin
            exp_q     <= exp_tt;
            tt        <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else if (wr) begin
            for (int k = 0; k < NOUT; k++) begin
                tt[IW'(tt_index(k, int'(code), WIDTH))] <= f_in[k];
            end
            // err_cnt is one bit wider than a code, so a full-table miss fits.
            if (mismatch) begin
                err_cnt <= err_cnt + (WIDTH + 1)'(1);
                if (err_cnt == '0) begin
                    first_err <= code;
                end
            end
        end
    end

endmodule

// File: rtl/comarray_sweep_ctrl.sv
// Sweeps the comarray input through every code, holding each for DWELL
// cycles before sampling f_in into the captured table.
module comarray_sweep_ctrl
    import comarray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NOUT  = NOUT_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NOUT*(2**WIDTH)-1:0]   exp_tt,
    input  logic [NOUT-1:0]              f_in,
    output logic [WIDTH-1:0]             a_out,
    output logic                         busy,
    output logic                         done,
    output logic [NOUT*(2**WIDTH)-1:0]   tt,
    output logic [WIDTH:0]               err_cnt,
    output logic [WIDTH-1:0]             first_err,
    output sweep_state_e                 state_dbg
);

    localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  DWELL_M1 = CW'(DWELL - 1);

    // Control handshake: start is a level sampled only in IDLE and is
    // accepted on an edge where start=1 and abort=0; abort is a level that
    // wins over everything in SETTLE/SAMPLE and leaves the partial table.
    sweep_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_d;
    logic             busy_d, done_d;
    logic             tt_clr, tt_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_out;
        tt_clr  = 1'b0;
        tt_wr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SETTLE;
                    cnt_d   = DWELL_M1;
                    tt_clr  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tt_wr = 1'b1;
                    // Test for the last code before incrementing so a_out never wraps.
                    if (&a_out) begin
                        state_d = ST_DONE;
                    end else begin
                        a_d     = a_out + WIDTH'(1);
                        cnt_d   = DWELL_M1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE) begin
            a_d = '0;
        end
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_out   <= a_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign state_dbg = state_q;

    comarray_tt_check #(
        .WIDTH (WIDTH),
        .NOUT  (NOUT)
    ) u_tt_check (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tt_clr),
        .wr        (tt_wr),
        .exp_tt    (exp_tt),
        .code      (a_out),
        .f_in      (f_in),
        .tt        (tt),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

endmodule

// File: tb/tb_comarray_sweep_ctrl.sv
// Bench for comarray_sweep_ctrl: a DWELL=2 and a DWELL=1 instance share the
// control inputs and are checked each cycle against a cycle-count model.
module tb_comarray_sweep_ctrl;
    import comarray_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [47:0] exp_tt;
    logic [15:0] fault_f2;

    logic [2:0]   f_in      [2];
    logic [3:0]   a_out     [2];
    logic         busy      [2];
    logic         done      [2];
    logic [47:0]  tt        [2];
    logic [4:0]   err_cnt   [2];
    logic [3:0]   first_err [2];
    sweep_state_e st_dbg    [2];

    int n_tests;
    int n_fail;
    int done_n0, done_n1, busy_n0;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    comarray_sweep_ctrl #(.WIDTH(4), .NOUT(3), .DWELL(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .exp_tt(exp_tt), .f_in(f_in[0]), .a_out(a_out[0]), .busy(busy[0]),
        .done(done[0]), .tt(tt[0]), .err_cnt(err_cnt[0]),
        .first_err(first_err[0]), .state_dbg(st_dbg[0])
    );

    comarray_sweep_ctrl #(.WIDTH(4), .NOUT(3), .DWELL(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .exp_tt(exp_tt), .f_in(f_in[1]), .a_out(a_out[1]), .busy(busy[1]),
        .done(done[1]), .tt(tt[1]), .err_cnt(err_cnt[1]),
        .first_err(first_err[1]), .state_dbg(st_dbg[1])
    );

    // Array model: f1 = a0^a1, f2 = &a, f3 = a3|a2; flt flips f2 at chosen codes.
    function automatic logic [2:0] f_model(input int c, input logic [15:0] flt);
        logic [3:0] a;
        logic [2:0] f;
        a    = c[3:0];
        f[0] = a[0] ^ a[1];
        f[1] = (&a) ^ flt[c];
        f[2] = a[3] | a[2];
        return f;
    endfunction

    function automatic logic [47:0] exp_table();
        logic [47:0] t;
        logic [2:0]  f;
        t = '0;
        for (int c = 0; c < 16; c++) begin
            f = f_model(c, 16'h0000);
            for (int k = 0; k < 3; k++) t[k*16 + c] = f[k];
        end
        return t;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) f_in[i] = f_model(int'(a_out[i]), fault_f2);
    end

    // Model: mode 0 idle, 1 sweeping (n = cycle number since start), 2 done.
    typedef struct {
        int          mode;
        int          n;
        logic [47:0] tt;
        int          err;
        int          first;
        logic [47:0] ex;
    } model_t;

    model_t m0, m1;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.n = 0; r.tt = '0; r.err = 0; r.first = 0; r.ex = '0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t cur, input int p, input logic st,
                                          input logic ab, input logic [47:0] ex_in,
                                          input logic [15:0] flt);
        model_t r;
        int     code;
        logic [2:0] fv;
        logic   bad;
        r = cur;
        if (cur.mode == 0) begin
            if (st && !ab) begin
                r = model_reset();
                r.mode = 1; r.n = 1; r.ex = ex_in;
            end
        end else if (cur.mode == 1) begin
            if (ab) begin
                r.mode = 0;
            end else begin
                if (cur.n % p == 0) begin
                    code = cur.n / p - 1;
                    fv   = f_model(code, flt);
                    bad  = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        r.tt[k*16 + code] = fv[k];
                        if (fv[k] != cur.ex[k*16 + code]) bad = 1'b1;
                    end
                    if (bad) begin
                        if (cur.err == 0) r.first = code;
                        r.err = cur.err + 1;
                    end
                    if (code == 15) r.mode = 2;
                end
                r.n = cur.n + 1;
            end
        end else begin
            r.mode = 0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= model_reset();
            m1 <= model_reset();
        end else begin
            m0 <= model_step(m0, 3, start, abort, exp_tt, fault_f2);
            m1 <= model_step(m1, 2, start, abort, exp_tt, fault_f2);
        end
    end

    // scoreboard: expected values queued per cycle, then popped against the DUT
    logic [63:0] exp_q[$];

    task automatic check(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", name, idx, $time, got, expv);
        end
    endtask

    task automatic compare_model(input int i, input model_t mm, input int p);
        exp_q.push_back((mm.mode == 1) ? 64'((mm.n - 1) / p) : (mm.mode == 2) ? 64'd15 : 64'd0);
        exp_q.push_back(64'(mm.mode == 1));
        exp_q.push_back(64'(mm.mode == 2));
        exp_q.push_back(64'(mm.tt));
        exp_q.push_back(64'(mm.err));
        exp_q.push_back(64'(mm.first));
        check("a_out",     i, 64'(a_out[i]),     exp_q.pop_front());
        check("busy",      i, 64'(busy[i]),      exp_q.pop_front());
        check("done",      i, 64'(done[i]),      exp_q.pop_front());
        check("tt",        i, 64'(tt[i]),        exp_q.pop_front());
        check("err_cnt",   i, 64'(err_cnt[i]),   exp_q.pop_front());
        check("first_err", i, 64'(first_err[i]), exp_q.pop_front());
    endtask

    // driver: advance cycles n=from..to, pulsing start/abort in chosen cycles,
    // and compare both instances against the model on every cycle.
    task automatic watch(input int from_n, input int to_n, input int st_n, input int ab_n);
        for (int n = from_n; n <= to_n; n++) begin
            @(negedge clk);
            start = (n == st_n);
            abort = (n == ab_n);
            if (n == 1) begin
                done_n0 = -1; done_n1 = -1; busy_n0 = 0;
            end
            if (done[0] && done_n0 < 0) done_n0 = n;
            if (done[1] && done_n1 < 0) done_n1 = n;
            if (busy[0]) busy_n0++;
            compare_model(0, m0, 3);
            compare_model(1, m1, 2);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_a_out"},   i, 64'(a_out[i]),     64'd0);
            check({tag, "_busy"},    i, 64'(busy[i]),      64'd0);
            check({tag, "_done"},    i, 64'(done[i]),      64'd0);
            check({tag, "_tt"},      i, 64'(tt[i]),        64'd0);
            check({tag, "_err"},     i, 64'(err_cnt[i]),   64'd0);
            check({tag, "_first"},   i, 64'(first_err[i]), 64'd0);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        start    = 1'b0;
        abort    = 1'b0;
        fault_f2 = 16'h0000;
        exp_tt   = exp_table();
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", 0, 64'(st_dbg[0]), 64'(ST_IDLE));
        rst_n = 1'b1;
        watch(1, 2, -1, -1);

        // Clean sweep: done at 49 (DWELL=2) and 33 (DWELL=1), busy for 48 cycles.
        start = 1'b1;
        watch(1, 52, -1, -1);
        check("clean_done_cyc", 0, 64'(done_n0), 64'd49);
        check("clean_done_cyc", 1, 64'(done_n1), 64'd33);
        check("clean_busy_cycles", 0, 64'(busy_n0), 64'd48);
        check("clean_tt_lit", 0, 64'(tt[0]), 64'h0000_FFF0_8000_6666);
        check("clean_tt_lit", 1, 64'(tt[1]), 64'h0000_FFF0_8000_6666);
        check("clean_err", 0, 64'(err_cnt[0]), 64'd0);

        // Injected f2 faults at codes 5 and 11.
        fault_f2 = 16'h0820;
        start = 1'b1;
        watch(1, 52, -1, -1);
        check("fault_err", 0, 64'(err_cnt[0]), 64'd2);
        check("fault_first", 0, 64'(first_err[0]), 64'd5);
        check("fault_err", 1, 64'(err_cnt[1]), 64'd2);
        check("fault_first", 1, 64'(first_err[1]), 64'd5);
        check("fault_tt_xor", 0, 64'(tt[0] ^ exp_tt), 64'h0000_0000_0820_0000);
        check("fault_tt_lit", 0, 64'(tt[0]), 64'h0000_FFF0_8820_6666);
        fault_f2 = 16'h0000;

        // Abort in cycle 22: DWELL=2 is settling code 7, DWELL=1 is sampling code 10.
        start = 1'b1;
        watch(1, 25, -1, 22);
        check("abort_busy", 0, 64'(busy[0]), 64'd0);
        check("abort_a_out", 0, 64'(a_out[0]), 64'd0);
        check("abort_no_done", 0, 64'(done_n0), -64'sd1);
        check("abort_no_done", 1, 64'(done_n1), -64'sd1);
        check("abort_tt_kept", 0, 64'(tt[0]), 64'(exp_tt & 48'h007F_007F_007F));
        check("abort_tt_kept", 1, 64'(tt[1]), 64'(exp_tt & 48'h03FF_03FF_03FF));
        watch(26, 30, -1, -1);

        // Second start at cycle 20 is ignored.
        start = 1'b1;
        watch(1, 52, 20, -1);
        check("restart_done_cyc", 0, 64'(done_n0), 64'd49);
        check("restart_done_cyc", 1, 64'(done_n1), 64'd33);

        // start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        watch(1, 3, -1, -1);
        check("start_abort_busy", 0, 64'(busy[0]), 64'd0);
        check("start_abort_busy", 1, 64'(busy[1]), 64'd0);

        // Asynchronous reset in the middle of cycle 30.
        start = 1'b1;
        watch(1, 30, -1, -1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch(1, 2, -1, -1);
        start = 1'b1;
        watch(1, 52, -1, -1);
        check("post_rst_done_cyc", 0, 64'(done_n0), 64'd49);
        check("post_rst_done_cyc", 1, 64'(done_n1), 64'd33);
        check("post_rst_tt", 0, 64'(tt[0]), 64'h0000_FFF0_8000_6666);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comarray_sweep_ctrl.md
# comarray_sweep_ctrl

Sequencer that drives the 4-bit input of the `comarray` combinational array through every code 0..15, holds each code for a settle window, and samples the f1/f2/f3 outputs into a captured truth table. It also compares the capture against an expected table and reports mismatches. It sits between a host/bench controller (start/abort handshake) and one `comarray` instance, replacing hand-written stimulus sweeps with a self-checking hardware sweep.

## Interface

Parameters:

- `WIDTH`, 4: width of the array input `a`; the sweep covers 2**WIDTH codes.
- `NOUT`, 3: number of array outputs sampled (f1..fNOUT).
- `DWELL`, 2: settle cycles per code before sampling; legal range is ≥ 1.

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `abort`  in  1  synchronous abort of a running sweep.
- `exp_tt`  in  NOUT*2**WIDTH  expected table; bit `k*2**WIDTH + code` is the expected f(k+1) at `code`. Sampled at start.
- `f_in`  in  NOUT  array outputs; bit k = f(k+1).
- `a_out`  out  WIDTH  code driven to the array `a`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes (not on abort).
- `tt`  out  NOUT*2**WIDTH  captured table, same bit layout as `exp_tt`.
- `err_cnt`  out  WIDTH+1  number of codes with at least one mismatching output.
- `first_err`  out  WIDTH  lowest mismatching code; valid when `err_cnt != 0`.

## Operation

- States are IDLE, SETTLE, SAMPLE and DONE.
- **IDLE:** `a_out` = 0 and `busy` = 0.
  - `start` = 1 and `abort` = 0 moves the FSM to SETTLE.
  - On that transition: load `exp_tt` into an internal register; clear `tt`, `err_cnt` and `first_err`; set `a_out` = 0; load the dwell counter with `DWELL-1`.
- **SETTLE:** `busy` = 1 and `a_out` is held. The dwell counter decrements each cycle; when it reads 0, the FSM moves to SAMPLE.
- **SAMPLE:** one cycle.
  - Write `f_in[k]` into `tt[k*2**WIDTH + a_out]` for every k.
  - If any bit differs from the registered expected table: increment `err_cnt`, and if `err_cnt` was 0, load `first_err` with `a_out`.
  - If `a_out` is all-ones, go to DONE. Otherwise set `a_out` to `a_out+1`, reload the dwell counter and go to SETTLE.
- **DONE:** `done` = 1 for one cycle, `busy` = 0, `a_out` stays at its last code. Next state is IDLE.
- **abort:** `abort` = 1 in SETTLE or SAMPLE returns the FSM to IDLE on the next edge.
  - No `done` pulse is issued.
  - If the abort arrives in SAMPLE, that sample is not written.
  - `tt`, `err_cnt` and `first_err` keep their partial values.
- `start` is ignored outside IDLE.
- `start` and `abort` high together in IDLE: the FSM stays in IDLE.
- `err_cnt` cannot overflow: the maximum is 2**WIDTH, and the port is WIDTH+1 bits wide.
- `a_out` increments are compared against all-ones before incrementing, so `a_out` never wraps during a sweep.

## Timing

- Reset values: state IDLE; `a_out`, `busy`, `done`, `tt`, `err_cnt` and `first_err` all 0; expected register 0; dwell counter 0.
- All outputs are registered. `busy` rises the cycle after `start` is accepted.
- Per-code cost is `DWELL` SETTLE cycles plus 1 SAMPLE cycle.
- `f_in` is sampled `DWELL` cycles after `a_out` changes, which gives the array `DWELL` full cycles to settle.
- `done` is high in cycle `2**WIDTH*(DWELL+1) + 1` after the `start` edge. With the defaults this is 16*3 + 1 = cycle 49.
- The final `tt`, `err_cnt` and `first_err` values are stable from the `done` cycle onward.
- Reset asserted mid-sweep clears everything immediately and asynchronously, with no `done` pulse.

## Structure

- Shared package `comarray_pkg`:
  - FSM state encoding (`ST_IDLE`, `ST_SETTLE`, `ST_SAMPLE`, `ST_DONE`).
  - Default `WIDTH`, `NOUT` and `DWELL` constants.
  - A function returning the table bit index `k*2**WIDTH + code`.
- One sub-module, `comarray_tt_check`: a registered table plus compare logic. It takes the write strobe, code and `f_in`, and maintains `tt`, `err_cnt` and `first_err`.
- The FSM and the dwell counter live in the top module.

## Test plan

- **Clean sweep:** the bench drives `f_in` from a model of `a_out` (f1 = a[0]^a[1], f2 = &a, f3 = a[3]|a[2]), with `exp_tt` matching and `start` pulsed once.
  - `a_out` steps 0..15, each code held 3 cycles.
  - `done` pulses at cycle 49; `busy` is 1 for cycles 1..48.
  - `tt` equals `exp_tt` and `err_cnt` = 0.
- **Injected faults:** the model flips f2 at codes 5 and 11.
  - `err_cnt` = 2 and `first_err` = 5.
  - `tt` bit 16+5 and bit 16+11 are inverted relative to `exp_tt`.
- **Abort:** `abort` asserted while `a_out` = 7 in SETTLE.
  - IDLE on the next edge, with no `done` pulse and `a_out` = 0.
  - `tt` entries for codes 0..6 are kept; codes 7..15 read 0.
- **Start while busy, and start with abort:**
  - A second `start` pulse at cycle 20 has no effect; `done` still pulses at cycle 49.
  - `start` and `abort` high together in IDLE leave `busy` = 0.
- **Reset mid-sweep:** `rst_n` pulled low asynchronously at cycle 30.
  - All outputs read 0 immediately.
  - After release, a new `start` runs a full sweep with `done` at cycle 49.
- **`DWELL` = 1 build:** `done` pulses at cycle 33 and every code is sampled 1 cycle after `a_out` changes.
